rf_scoreboard: RTL and testbench

- Issue-stage scheduler for the pipeline register file (32 x 32-bit, 5-bit register addresses, r0 hard-wired to zero).
- Tracks in-flight writes to every architectural register and stalls issue of an instruction whose sources are pending.
- Also stalls when a destination's pending counter would overflow.
- Sits between decode/issue and the RF. It never touches RF data, only sequences access to it.

---
 rtl/rf_scoreboard.sv | 96 +++++++++
 tb/tb_rf_scoreboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_scoreboard.sv
// Issue-stage register scoreboard: per-register pending-write counters that
// stall issue on RAW hazards and on counter saturation, with same-cycle writeback bypass.
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 2,
    parameter int TW   = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rs,
    input  logic [AW-1:0] issue_rt,
    input  logic          issue_use_rs,
    input  logic          issue_use_rt,
    input  logic          issue_wr,
    input  logic [AW-1:0] issue_rd,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_rd,
    output logic          stall,
    output logic          issue_fire,
    output logic [TW-1:0] pending_total,
    output logic          err
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [NREG-1:0][CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0]           pending_total_q, pending_total_d;
    logic                    err_q, err_d;

    logic [CW-1:0] cnt_rs, cnt_rt, cnt_rd, cnt_wb;
    logic          rs_haz, rt_haz, rd_haz;
    logic          inc, dec, wb_bad, same_reg;

    // A source whose only pending write retires this cycle is readable: the RF writes on the falling edge.
    always_comb begin
        cnt_rs = cnt_q[issue_rs];
        cnt_rt = cnt_q[issue_rt];
        cnt_rd = cnt_q[issue_rd];
        cnt_wb = cnt_q[wb_rd];

        rs_haz = issue_use_rs && (issue_rs != '0) && (cnt_rs != '0) &&
                 !(wb_valid && (wb_rd == issue_rs) && (cnt_rs == CNT_ONE));
        rt_haz = issue_use_rt && (issue_rt != '0) && (cnt_rt != '0) &&
                 !(wb_valid && (wb_rd == issue_rt) && (cnt_rt == CNT_ONE));
        rd_haz = issue_wr && (issue_rd != '0) && (cnt_rd == CNT_MAX) &&
                 !(wb_valid && (wb_rd == issue_rd));

        stall      = issue_valid && (rs_haz || rt_haz || rd_haz);
        issue_fire = issue_valid && !stall;

        inc      = issue_fire && issue_wr && (issue_rd != '0);
        dec      = wb_valid && (wb_rd != '0) && (cnt_wb != '0);
        wb_bad   = wb_valid && (wb_rd != '0) && (cnt_wb == '0);
        same_reg = inc && dec && (issue_rd == wb_rd);
    end

    always_comb begin
        cnt_d           = cnt_q;
        pending_total_d = pending_total_q;
        err_d           = err_q;
        if (flush) begin
            cnt_d           = '0;
            pending_total_d = '0;
        end else begin
            if (inc && !same_reg) begin
                cnt_d[issue_rd] = cnt_q[issue_rd] + CNT_ONE;
            end
            if (dec && !same_reg) begin
                cnt_d[wb_rd] = cnt_q[wb_rd] - CNT_ONE;
            end
            pending_total_d = pending_total_q + TW'(inc) - TW'(dec);
            err_d           = err_q || wb_bad;
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q           <= '0;
            pending_total_q <= '0;
            err_q           <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            pending_total_q <= pending_total_d;
            err_q           <= err_d;
        end
    end

    assign pending_total = pending_total_q;
    assign err           = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a counting model of the scoreboard.
module tb_rf_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int TW   = 6;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          issue_valid;
    logic [AW-1:0] issue_rs;
    logic [AW-1:0] issue_rt;
    logic          issue_use_rs;
    logic          issue_use_rt;
    logic          issue_wr;
    logic [AW-1:0] issue_rd;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          stall;
    logic          issue_fire;
    logic [TW-1:0] pending_total;
    logic          err;

    int tests_run = 0;
    int fail_count = 0;

    int  mcnt [NREG];
    bit  merr;
    bit  m_fire, m_inc, m_dec, m_bad;

    rf_scoreboard #(.NREG(NREG), .AW(AW), .CW(CW), .TW(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_use_rs (issue_use_rs),
        .issue_use_rt (issue_use_rt),
        .issue_wr     (issue_wr),
        .issue_rd     (issue_rd),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .stall        (stall),
        .issue_fire   (issue_fire),
        .pending_total(pending_total),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Reference: a plain count of outstanding writes per register.
    function automatic bit srcBlocked(input bit use_s, input int s);
        if (!use_s || s == 0 || mcnt[s] == 0) return 1'b0;
        if (wb_valid && int'(wb_rd) == s && mcnt[s] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit modelStall();
        bit full;
        full = issue_wr && issue_rd != 0 && mcnt[issue_rd] == MAXC &&
               !(wb_valid && wb_rd == issue_rd);
        return issue_valid && (srcBlocked(issue_use_rs, int'(issue_rs)) ||
                               srcBlocked(issue_use_rt, int'(issue_rt)) || full);
    endfunction

    function automatic int modelTotal();
        int sum = 0;
        for (int i = 0; i < NREG; i++) sum += mcnt[i];
        return sum % (1 << TW);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) mcnt[i] = 0;
            merr = 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NREG; i++) mcnt[i] = 0;
        end else begin
            m_fire = issue_valid && !modelStall();
            m_inc  = m_fire && issue_wr && issue_rd != 0;
            m_dec  = wb_valid && wb_rd != 0 && mcnt[wb_rd] > 0;
            m_bad  = wb_valid && wb_rd != 0 && mcnt[wb_rd] == 0;
            if (m_inc) mcnt[issue_rd] = mcnt[issue_rd] + 1;
            if (m_dec) mcnt[wb_rd] = mcnt[wb_rd] - 1;
            if (m_bad) merr = 1'b1;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput();
        bit exp_stall;
        exp_stall = modelStall();
        check("stall", int'(stall), int'(exp_stall));
        check("issue_fire", int'(issue_fire), int'(issue_valid && !exp_stall));
        check("pending_total", int'(pending_total), modelTotal());
        check("err", int'(err), int'(merr));
    endtask

    task automatic applyStimulus(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                                 input bit wr, input int rd, input bit wbv, input int wbr, input bit fl);
        issue_valid  = v;
        issue_rs     = AW'(rs);
        issue_use_rs = urs;
        issue_rt     = AW'(rt);
        issue_use_rt = urt;
        issue_wr     = wr;
        issue_rd     = AW'(rd);
        wb_valid     = wbv;
        wb_rd        = AW'(wbr);
        flush        = fl;
    endtask

    task automatic toNeg();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic toPos();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int pickReg();
        if ($urandom_range(0, 9) < 8) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, NREG - 1));
    endfunction

    initial begin
        rst = 1'b0;
        idle();
        #12;
        rst = 1'b1;
        toPos();

        // RAW hazard on r7 with writeback bypass
        applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        toNeg(); check("raw_first_fire", int'(issue_fire), 1); toPos();
        applyStimulus(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        toNeg(); check("raw_stall", int'(stall), 1); check("raw_total", int'(pending_total), 1); toPos();
        toNeg(); check("raw_stall_hold", int'(stall), 1); toPos();
        applyStimulus(1, 7, 1, 0, 0, 0, 0, 1, 7, 0);
        toNeg(); check("raw_bypass", int'(stall), 0); toPos();
        idle();
        toNeg(); check("raw_drained", int'(pending_total), 0); toPos();

        // r0 is never tracked
        applyStimulus(1, 0, 1, 0, 1, 1, 0, 1, 0, 0);
        toNeg(); check("r0_stall", int'(stall), 0); toPos();
        toNeg(); check("r0_stall2", int'(stall), 0); check("r0_total", int'(pending_total), 0);
        check("r0_err", int'(err), 0); toPos();

        // Saturate r9
        applyStimulus(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            toNeg(); check("sat_fill", int'(stall), 0); toPos();
        end
        toNeg(); check("sat_stall", int'(stall), 1); check("sat_total", int'(pending_total), 3); toPos();
        applyStimulus(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
        toNeg(); check("sat_wb_release", int'(stall), 0); toPos();
        idle();
        toNeg(); check("sat_total_kept", int'(pending_total), 3); toPos();

        // Simultaneous inc of r4 and dec of r12
        applyStimulus(1, 0, 0, 0, 0, 1, 12, 0, 0, 0);
        toPos();
        applyStimulus(1, 0, 0, 0, 0, 1, 4, 1, 12, 0);
        toNeg(); check("simul_before", int'(pending_total), 4); toPos();
        applyStimulus(1, 12, 1, 4, 0, 0, 0, 0, 0, 0);
        toNeg(); check("simul_total", int'(pending_total), 4); check("simul_r12_free", int'(stall), 0); toPos();

        // Writeback to an idle register, then flush
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 20, 0);
        toNeg(); check("err_before", int'(err), 0); toPos();
        idle();
        toNeg(); check("err_set", int'(err), 1); check("err_total", int'(pending_total), 4); toPos();
        applyStimulus(1, 9, 1, 4, 1, 0, 0, 0, 0, 1);
        toNeg(); check("flush_stall_same_cycle", int'(stall), 1); toPos();
        applyStimulus(1, 9, 1, 4, 1, 1, 9, 0, 0, 0);
        toNeg(); check("flush_total", int'(pending_total), 0); check("flush_stall", int'(stall), 0);
        check("flush_err_held", int'(err), 1); toPos();

        // Asynchronous reset mid-run with cnt[5]=2
        applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        toPos();
        toPos();
        idle();
        #2;
        rst = 1'b0;
        #1;
        check("rst_total", int'(pending_total), 0);
        check("rst_err", int'(err), 0);
        applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_stall", int'(stall), 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        toPos();

        // Randomized traffic; decode holds a stalled instruction stable
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!(issue_valid && stall && $urandom_range(0, 3) != 0)) begin
                issue_valid  = $urandom_range(0, 3) != 0;
                issue_rs     = AW'(pickReg());
                issue_rt     = AW'(pickReg());
                issue_use_rs = $urandom_range(0, 1);
                issue_use_rt = $urandom_range(0, 1);
                issue_wr     = $urandom_range(0, 2) != 0;
                issue_rd     = AW'(pickReg());
            end
            wb_valid = $urandom_range(0, 2) != 0;
            wb_rd    = AW'(pickReg());
            flush    = $urandom_range(0, 59) == 0;
            toNeg();
            if (cyc % 700 == 699) begin
                #1;
                rst = 1'b0;
                #1;
                check("rand_rst_total", int'(pending_total), 0);
                rst = 1'b1;
            end
            toPos();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
